// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states, ready and start levels.
package div_unit_pkg;

   localparam logic [1:0] DivFree   = 2'b00;
   localparam logic [1:0] DivByZero = 2'b01;
   localparam logic [1:0] DivOn     = 2'b10;
   localparam logic [1:0] DivEnd    = 2'b11;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   localparam logic DivStart = 1'b1;
   localparam logic DivStop  = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient} for HI/LO.
// Optional DIV_FAST_ZERO_EN short-cuts a zero divisor through BYZERO instead of 32 iterations.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_dvd;
   logic [DATA_W-1:0] r_dvs;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_by_zero;

   logic [DATA_W-1:0] w_abs_a;
   logic [DATA_W-1:0] w_abs_b;
   logic [DATA_W:0]   w_shift_rem;
   logic [DATA_W:0]   w_trial;
   logic [DATA_W-1:0] w_quot_fix;
   logic [DATA_W-1:0] w_rem_fix;

   assign w_abs_a = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
   assign w_abs_b = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

   // r_dvd shifts out dividend bits at the top and collects quotient bits at the bottom.
   assign w_shift_rem = {r_rem, r_dvd[DATA_W-1]};
   assign w_trial     = w_shift_rem - {1'b0, r_dvs};

   assign w_quot_fix = r_neg_q ? -r_dvd : r_dvd;
   assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= DivFree;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_dvd     <= '0;
         r_dvs     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_by_zero <= 1'b0;
         result_o  <= '0;
         ready_o   <= DivResultNotReady;
      end else begin
         case (r_state)
            DivFree: begin
               if (start_i == DivStart && !annul_i) begin
                  r_dvd     <= w_abs_a;
                  r_dvs     <= w_abs_b;
                  r_rem     <= '0;
                  r_cnt     <= '0;
                  r_neg_q   <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                  r_neg_r   <= signed_div_i && opdata1_i[DATA_W-1];
                  r_by_zero <= (opdata2_i == '0);
                  r_state   <= DivOn;
`ifdef DIV_FAST_ZERO_EN
                  if (opdata2_i == '0) r_state <= DivByZero;
`endif
               end
            end

            // Only reachable when the fast zero-divisor path is built in.
            DivByZero: begin
               r_state <= annul_i ? DivFree : DivEnd;
            end

            DivOn: begin
               if (annul_i) begin
                  r_state  <= DivFree;
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end else begin
                  if (!w_trial[DATA_W]) begin
                     r_rem <= w_trial[DATA_W-1:0];
                     r_dvd <= {r_dvd[DATA_W-2:0], 1'b1};
                  end else begin
                     r_rem <= w_shift_rem[DATA_W-1:0];
                     r_dvd <= {r_dvd[DATA_W-2:0], 1'b0};
                  end
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_W'(DATA_W - 1)) r_state <= DivEnd;
               end
            end

            DivEnd: begin
               if (start_i == DivStop) begin
                  r_state  <= DivFree;
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end else begin
                  result_o <= r_by_zero ? '0 : {w_rem_fix, w_quot_fix};
                  ready_o  <= DivResultReady;
               end
            end

            default: r_state <= DivFree;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a negedge monitor checks them.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

`ifdef DIV_FAST_ZERO_EN
   localparam int ZeroLat = 2;
`else
   localparam int ZeroLat = 33;
`endif

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          issue;
      string       name;
   } exp_t;

   exp_t sb[$];

   div_unit #(.DATA_W(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every rising ready_o must match the oldest outstanding expectation.
   logic prev_ready = 1'b0;
   always @(negedge clk) begin
      if (rst && ready_o && !prev_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_ready", 64'(ready_o), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, result_o, e.res);
            check({e.name, "_latency"}, 64'(cyc - e.issue - 1), 64'(e.lat));
         end
      end
      prev_ready = ready_o;
   end

   // Issue one division, scramble operands while it runs, then either release start or reset in END.
   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string name, input bit reset_in_end);
      @(negedge clk);
      signed_div_i = s;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      sb.push_back('{exp, (b == 32'd0) ? ZeroLat : 33, cyc, name});
      @(negedge clk);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~s;
      for (int i = 0; i < 60 && !ready_o; i++) @(negedge clk);
      if (!ready_o) begin
         check({name, "_timeout"}, 64'(ready_o), 64'd1);
         void'(sb.pop_front());
      end
      @(negedge clk);
      check({name, "_hold_ready"}, 64'(ready_o), 64'd1);
      check({name, "_hold_result"}, result_o, exp);
      if (reset_in_end) begin
         #2 rst = 1'b0;
         #1;
         check({name, "_async_rst_ready"}, 64'(ready_o), 64'd0);
         check({name, "_async_rst_result"}, result_o, 64'd0);
         start_i = 1'b0;
         @(negedge clk);
         rst = 1'b1;
      end else begin
         start_i = 1'b0;
         @(negedge clk);
         check({name, "_drop_ready"}, 64'(ready_o), 64'd0);
         check({name, "_drop_result"}, result_o, 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ready", 64'(ready_o), 64'd0);
      check("reset_result", result_o, 64'd0);
      rst = 1'b1;

      run_op(1'b0, 32'd100,       32'd7,          {32'h00000002, 32'h0000000E}, "divu_100_7", 1'b0);
      run_op(1'b1, 32'hFFFFFFF9,  32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, "div_m7_2", 1'b0);
      run_op(1'b1, 32'd7,         32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, "div_7_m2", 1'b0);
      run_op(1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,   {32'hFFFFFFFE, 32'h0000000E}, "div_m100_m7", 1'b0);
      run_op(1'b0, 32'h12345678,  32'd0,          64'd0,                        "div_by_zero", 1'b0);
      run_op(1'b1, 32'h80000000,  32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, "div_min_m1", 1'b0);
      run_op(1'b0, 32'hFFFFFFFF,  32'd1,          {32'h00000000, 32'hFFFFFFFF}, "divu_max_1", 1'b0);
      run_op(1'b0, 32'd5,         32'd9,          {32'h00000005, 32'h00000000}, "divu_5_9", 1'b0);
      run_op(1'b0, 32'hFFFFFFFF,  32'h00010000,   {32'h0000FFFF, 32'h0000FFFF}, "divu_max_64k", 1'b0);

      // Annul after ten iterations: no result may appear.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'hFFFFFFFF;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      repeat (11) @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      check("annul_ready", 64'(ready_o), 64'd0);
      check("annul_result", result_o, 64'd0);
      repeat (40) @(negedge clk);
      check("annul_quiet", 64'(ready_o), 64'd0);
      run_op(1'b0, 32'd9, 32'd3, {32'h00000000, 32'h00000003}, "after_annul_9_3", 1'b0);

      // Asynchronous reset in the middle of an iteration run.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_mid_on_ready", 64'(ready_o), 64'd0);
      check("rst_mid_on_result", result_o, 64'd0);
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      check("rst_mid_on_quiet", 64'(ready_o), 64'd0);
      run_op(1'b0, 32'd1000, 32'd3, {32'h00000001, 32'h0000014D}, "after_rst_1000_3", 1'b1);
      run_op(1'b1, 32'd9,    32'd3, {32'h00000000, 32'h00000003}, "after_rst_end_9_3", 1'b0);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for DIV/DIVU, driven by the EX stage.
- Produces the 64-bit {remainder, quotient} pair, which flows through MEM/WB into hilo_reg: HI gets the remainder, LO gets the quotient.
- EX stalls the pipeline while start_i is high and ready_o is low.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- DATA_W, 32, operand width; the result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request; held high by EX until ready_o is seen.
- annul_i  in  1  abort in-flight operation (flush/exception).
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result_o valid.

Behaviour:
- Reset (rst=0, asynchronous): state=FREE, counter=0, result_o=0, ready_o=0. Reset mid-operation discards all work.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 & annul_i=0 & opdata2_i!=0 -> ON.
  - On this edge the unit latches |dividend| and |divisor| (absolute values only when signed_div_i=1) and the sign flags, and clears the counter and partial remainder.
  - start_i=1 & opdata2_i==0: see Optional Feature.
- ON, each cycle:
  - Shift {rem, dvd} left by 1.
  - Trial = rem - divisor. If non-negative, rem=trial and the quotient LSB is 1; otherwise the LSB is 0.
  - Counter increments.
  - After 32 iteration edges -> END.
- END:
  - result_o holds the sign-corrected values.
  - Quotient is negated if the operand signs differ (signed only).
  - Remainder takes the sign of the dividend.
  - ready_o=1.
  - Stays in END while start_i=1. start_i=0 -> FREE, ready_o=0, result_o=0.
- Latency: start sampled at edge k -> ready_o high after edge k+33.
- annul_i=1 in ON or BYZERO -> FREE on the next edge, ready_o=0, result_o=0. annul_i has no effect in END.
- Operands are sampled only at acceptance. Changes during ON are ignored.
- Divisor 0: result_o = 0 (quotient 0, remainder 0).
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (wraps, no trap).
- ready_o is never asserted outside END.

Optional Feature:
- Macro: DIV_FAST_ZERO_EN.
- Defined:
  - A zero divisor in FREE with start_i=1 -> BYZERO for one cycle, then END with result 0.
  - ready_o is high after edge k+2.
- Undefined:
  - There is no BYZERO state; a zero divisor enters ON and runs the full 32 iterations.
  - END forces result_o=0, so ready_o is high after edge k+33.
- Results are identical either way; only latency differs.

Decomposition:
- Shared defines.v gains:
  - state encodings DivFree/DivByZero/DivOn/DivEnd (2-bit);
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop.
- ZeroWord and RegBus are reused.
- No sub-module. Negation/abs is inline two's-complement; the datapath is a single 33-bit subtractor.

Test Plan:
- DIVU 100/7 -> after 33 cycles ready_o=1, result_o={0x00000002, 0x0000000E}; start_i low -> ready_o=0 next cycle.
- DIV -7/2 (0xFFFFFFF9/2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide 0x12345678 by 0:
  - with DIV_FAST_ZERO_EN -> ready_o after 2 cycles;
  - without it -> after 33 cycles;
  - result_o=0 in both.
- DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Start DIVU 0xFFFFFFFF/3, pulse annul_i at iteration 10 -> FREE next cycle, ready_o stays 0. A new start 9/3 then yields {0, 3}.
- Assert rst=0 asynchronously mid-ON -> ready_o=0 and result_o=0 immediately. After release, the unit accepts a new start normally.
